// File: rtl/button_cmd_encoder_if.sv
// Byte stream handshake between the button encoder and a UART transmitter.
// The encoder drives master; the transmitter side uses slave.
interface button_cmd_encoder_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/button_cmd_encoder.sv
// Turns rising edges on four debounced buttons into command bytes,
// queued lowest-index first through a small FIFO towards a UART.
module button_cmd_encoder #(
    parameter logic [7:0] CODE_BASE  = 8'h30,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           buttons,
    input  logic                 clr_ovf,
    button_cmd_encoder_if.master tx,
    output logic                 overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [3:0]    prev;
    logic [3:0]    pending;
    logic          armed;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [7:0]    mem [FIFO_DEPTH];

    logic [3:0] rise;
    logic [3:0] sel;
    logic [3:0] clr;
    logic [1:0] idx;
    logic       found;
    logic       full;
    logic       push;
    logic       pop;
    logic       ovf_set;
    logic [7:0] code;

    // armed stays low for the first edge after reset so a held button
    // only loads prev and must be released before it can fire
    assign rise = armed ? (buttons & ~prev) : 4'b0000;

    always_comb begin
        sel   = 4'b0000;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pending[i] && !found) begin
                sel[i] = 1'b1;
                idx    = 2'(i);
                found  = 1'b1;
            end
        end
    end

    assign full    = (count == CW'(FIFO_DEPTH));
    assign push    = found && !full;
    assign pop     = (count != '0) && tx.tx_ready;
    assign clr     = push ? sel : 4'b0000;
    assign ovf_set = |(rise & pending & ~clr);
    assign code    = CODE_BASE + 8'(idx);

    assign tx.tx_valid = (count != '0);
    assign tx.tx_data  = (count != '0) ? mem[rptr] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= 4'b0000;
            pending  <= 4'b0000;
            armed    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            prev     <= buttons;
            armed    <= 1'b1;
            pending  <= (pending & ~clr) | rise;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: tx_data is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= code;
        end
    end
endmodule

// File: tb/tb_button_cmd_encoder.sv
// Self-checking bench: directed scenarios plus random presses,
// compared each cycle against a queue-based behavioural model.
module tb_button_cmd_encoder;
    localparam logic [7:0] BASE  = 8'h30;
    localparam int         DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] buttons;
    logic       clr_ovf;
    logic       overflow;

    int passed;
    int total;

    button_cmd_encoder_if bus ();

    button_cmd_encoder #(
        .CODE_BASE  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .buttons  (buttons),
        .clr_ovf  (clr_ovf),
        .tx       (bus.master),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model state
    bit [3:0]   m_prev;
    bit [3:0]   m_pend;
    bit         m_armed;
    bit         m_ovf;
    logic [7:0] m_q[$];

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] ed;
        logic       ev;
        ev = (m_q.size() != 0);
        ed = ev ? m_q[0] : 8'h00;
        check({tag, ".valid"}, {7'd0, bus.tx_valid}, {7'd0, ev});
        check({tag, ".data"}, bus.tx_data, ed);
        check({tag, ".ovf"}, {7'd0, overflow}, {7'd0, m_ovf});
    endtask

    // effect of one rising edge with the given inputs
    task automatic model_edge(input bit [3:0] b,
                              input bit rdy,
                              input bit c);
        bit [3:0] rise;
        bit [3:0] cleared;
        bit       was_full;
        bit       set;
        rise     = m_armed ? (b & ~m_prev) : 4'b0000;
        cleared  = 4'b0000;
        was_full = (m_q.size() == DEPTH);
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (m_pend != 0 && !was_full) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i] && cleared == 0) begin
                    cleared[i] = 1'b1;
                    m_q.push_back(BASE + 8'(i));
                end
            end
        end
        set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rise[i] && m_pend[i] && !cleared[i]) set = 1'b1;
        end
        m_pend = (m_pend & ~cleared) | rise;
        if (set) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        m_prev  = b;
        m_armed = 1'b1;
    endtask

    task automatic step(input string tag,
                        input bit [3:0] b,
                        input bit rdy,
                        input bit c);
        @(negedge clk);
        check_outputs(tag);
        buttons  = b;
        bus.tx_ready = rdy;
        clr_ovf  = c;
        model_edge(b, rdy, c);
    endtask

    task automatic do_reset(input bit [3:0] b);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        buttons = b;
        clr_ovf = 1'b0;
        #1;
        check("rst.valid", {7'd0, bus.tx_valid}, 8'h00);
        check("rst.data", bus.tx_data, 8'h00);
        check("rst.ovf", {7'd0, overflow}, 8'h00);
        m_q.delete();
        m_pend  = '0;
        m_prev  = '0;
        m_armed = 1'b0;
        m_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_edge(b, bus.tx_ready, 1'b0);
    endtask

    initial begin
        bit [3:0] b;
        passed       = 0;
        total        = 0;
        rst_n        = 1'b0;
        buttons      = 4'b0000;
        clr_ovf      = 1'b0;
        bus.tx_ready = 1'b1;

        do_reset(4'b0000);
        step("idle", 4'b0000, 1, 0);

        // single press
        step("single", 4'b0001, 1, 0);
        repeat (4) step("single", 4'b0001, 1, 0);
        repeat (2) step("single", 4'b0000, 1, 0);

        // simultaneous press
        step("simul", 4'b1010, 1, 0);
        repeat (4) step("simul", 4'b1010, 1, 0);
        repeat (2) step("simul", 4'b0000, 1, 0);

        // backpressure: five presses, FIFO holds four
        for (int i = 0; i < 5; i++) begin
            b = 4'(1 << (i % 4));
            step("bp", b, 0, 0);
            step("bp", b, 0, 0);
            step("bp", 4'b0000, 0, 0);
        end

        // overflow on button 2 while FIFO full
        step("ovf", 4'b0100, 0, 0);
        step("ovf", 4'b0000, 0, 0);
        step("ovf", 4'b0100, 0, 0);
        repeat (3) step("ovf", 4'b0000, 0, 0);
        step("ovf", 4'b0000, 0, 1);
        repeat (2) step("ovf", 4'b0000, 0, 0);

        // drain
        repeat (10) step("drain", 4'b0000, 1, 0);

        // reset mid-queue with button 0 held
        for (int i = 0; i < 3; i++) begin
            b = 4'(1 << i);
            step("mq", b, 0, 0);
            step("mq", 4'b0000, 0, 0);
        end
        repeat (3) step("mq", 4'b0001, 0, 0);
        do_reset(4'b0001);
        repeat (4) step("held", 4'b0001, 1, 0);
        step("held", 4'b0000, 1, 0);
        step("held", 4'b0001, 1, 0);
        repeat (4) step("held", 4'b0000, 1, 0);

        // twenty sequential presses with random ready
        for (int k = 0; k < 20; k++) begin
            b = 4'(1 << $urandom_range(0, 3));
            step("wrap", b, 1'($urandom_range(0, 1)), 0);
            step("wrap", 4'b0000, 1'($urandom_range(0, 1)), 0);
        end
        repeat (12) step("wrap", 4'b0000, 1, 0);

        // fully random traffic
        for (int k = 0; k < 400; k++) begin
            step("rand", 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0));
        end
        repeat (12) step("end", 4'b0000, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/button_cmd_encoder.md
BUTTON_CMD_ENCODER -- requirements
Module: button_cmd_encoder

Interface
REQ-001 SHALL have parameter CODE_BASE, default 8'h30, byte code emitted for button index 0; index i emits CODE_BASE+i, modulo 256.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command FIFO depth; power of two, 2 to 16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port buttons  input  4  debounced button levels from the debouncer; 1 = pressed.
REQ-006 SHALL have port clr_ovf  input  1  synchronous clear of overflow.
REQ-007 SHALL have port tx_ready  input  1  UART transmitter accepts tx_data this cycle.
REQ-008 SHALL have port tx_valid  output  1  FIFO non-empty; tx_data is valid.
REQ-009 SHALL have port tx_data  output  8  command byte at FIFO head.
REQ-010 SHALL have port overflow  output  1  sticky flag: one or more presses were lost.

Function
REQ-011 SHALL register buttons into prev[3:0] every cycle; rise[i] = buttons[i] & ~prev[i]; falling edges are ignored.
REQ-012 SHALL OR rise into pending[3:0] on each edge; pending holds presses not yet queued.
REQ-013 SHALL set overflow if rise[i] occurs while pending[i] is already 1; that press is dropped and pending[i] stays 1.
REQ-014 SHALL, each cycle that pending is non-zero and the FIFO is not full, push the code of the lowest-index set pending bit and clear that bit in the same edge.
REQ-015 SHALL push at most one entry per cycle; remaining pending bits are pushed on later cycles in ascending index order.
REQ-016 SHALL evaluate full on the pre-edge count; a push while full is blocked even if a pop occurs on the same edge, and pending is retained.
REQ-017 SHALL, when a pending bit is cleared by a push on the same edge that the same bit rises, leave pending[i]=1 with no overflow.
REQ-018 SHALL drive tx_valid = (count != 0) and tx_data = FIFO head, both from registered state with no combinational path from tx_ready.
REQ-019 SHALL pop on tx_valid & tx_ready; tx_data SHALL stay stable while tx_valid & ~tx_ready.
REQ-020 SHALL allow a simultaneous push and pop when not full; count is then unchanged.
REQ-021 SHALL wrap read and write pointers modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-022 SHALL assert tx_valid on the second clock edge after buttons[i] first samples 1 with the FIFO empty: edge 1 sets pending, edge 2 pushes.
REQ-023 SHALL clear overflow on clr_ovf; a set and a clear on the same edge SHALL resolve to set.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear prev, pending, FIFO pointers, count and overflow; tx_valid=0, tx_data=0.
REQ-025 SHALL discard all queued and pending commands on reset mid-operation.
REQ-026 SHALL NOT report a press for a button held high through reset release until that button falls and rises again; prev SHALL load 1 on the first edge without generating rise.

Verification
REQ-027 Single press: buttons=0001, tx_ready=1 -> tx_valid high 2 edges later with tx_data=8'h30 for exactly 1 cycle; overflow=0.
REQ-028 Simultaneous press: buttons 0000->1010, tx_ready=1 -> bytes 8'h31 then 8'h33 on consecutive cycles.
REQ-029 Backpressure: tx_ready=0, press buttons 0,1,2,3,0 in sequence -> 4 entries queued, 5th held in pending; raising tx_ready drains 30,31,32,33,30 in order.
REQ-030 Overflow: tx_ready=0, FIFO full, pending[2]=1, button 2 pulses again -> overflow=1 and stays 1; clr_ovf pulse -> overflow=0.
REQ-031 Reset mid-queue: 3 entries queued, rst_n pulsed low -> tx_valid=0 immediately; buttons held 0001 through reset -> no byte until release and re-press.
REQ-032 Wrap: 20 sequential presses with random tx_ready -> output stream matches press order; pointers wrap correctly; no loss or duplication.
